// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and widths for the two-requester SRAM port arbiter.
package sram_arb_pkg;
  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  typedef enum logic [1:0] {S_IDLE, S_OWN0, S_OWN1} state_t;
  typedef struct packed {
    logic valid;
    logic owner;
  } read_tag_t;
  function automatic state_t own_state(input logic o);
    return o ? S_OWN1 : S_OWN0;
  endfunction
endpackage

// File: rtl/sram_read_tag_pipe.sv
// sram_read_tag_pipe: shift register that carries {valid, owner} read tags alongside the SRAM read latency.
module sram_read_tag_pipe
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_owner,
  output logic out_valid,
  output logic out_owner
);
  read_tag_t pipe [DEPTH];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= '{valid: in_valid, owner: in_owner};
      for (int k = 1; k < DEPTH; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign out_valid = pipe[DEPTH-1].valid;
  assign out_owner = pipe[DEPTH-1].owner;
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin, burst-bounded sharing of one SRAM controller port between two requesters,
// with read data tagged back to the requester that issued it.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int READ_LATENCY = 3,
  parameter int MAX_BURST    = 16
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  input  logic                     SRAM_ready,
  input  logic [1:0]               Req,
  input  logic [1:0]               Req_we_n,
  input  logic [2*SRAM_ADDR_W-1:0] Req_address,
  input  logic [2*SRAM_DATA_W-1:0] Req_write_data,
  output logic [1:0]               Grant,
  output logic [1:0]               Read_valid,
  output logic [SRAM_DATA_W-1:0]   Read_data,
  output logic [SRAM_ADDR_W-1:0]   SRAM_address,
  output logic [SRAM_DATA_W-1:0]   SRAM_write_data,
  output logic                     SRAM_we_n,
  input  logic [SRAM_DATA_W-1:0]   SRAM_read_data
);
  localparam int CW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic last_owner, last_n, owner, issue, expire, tag_valid, tag_owner;
  assign owner  = state == S_OWN1;
  assign issue  = SRAM_ready && state != S_IDLE && Req[owner];
  assign expire = issue && cnt == LAST;
  // A sole requester at burst expiry keeps the port; only a waiting peer forces a hand-over.
  always_comb begin
    state_n = state;
    if (!SRAM_ready) state_n = S_IDLE;
    else if (state == S_IDLE)
      state_n = Req == 2'b11 ? own_state(!last_owner) : Req[0] ? S_OWN0 : Req[1] ? S_OWN1 : S_IDLE;
    else if (!Req[owner]) state_n = Req[!owner] ? own_state(!owner) : S_IDLE;
    else if (expire && Req[!owner]) state_n = own_state(!owner);
    cnt_n  = (state_n != state || expire) ? '0 : issue ? cnt + 1'b1 : cnt;
    last_n = (state_n == S_IDLE || state_n == state) ? last_owner : state_n == S_OWN1;
  end
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      last_owner <= 1'b1;
      Grant      <= 2'b00;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      last_owner <= last_n;
      Grant      <= {state_n == S_OWN1, state_n == S_OWN0};
    end
  end
  assign SRAM_address    = issue ? (owner ? Req_address[2*SRAM_ADDR_W-1:SRAM_ADDR_W] : Req_address[SRAM_ADDR_W-1:0]) : '0;
  assign SRAM_write_data = issue ? (owner ? Req_write_data[2*SRAM_DATA_W-1:SRAM_DATA_W] : Req_write_data[SRAM_DATA_W-1:0]) : '0;
  assign SRAM_we_n       = issue ? Req_we_n[owner] : 1'b1;
  sram_read_tag_pipe #(.DEPTH(READ_LATENCY)) u_tag (
    .clk      (Clock),
    .rst_n    (Resetn),
    .in_valid (issue && Req_we_n[owner]),
    .in_owner (owner),
    .out_valid(tag_valid),
    .out_owner(tag_owner)
  );
  assign Read_valid = {tag_valid && tag_owner, tag_valid && !tag_owner};
  assign Read_data  = SRAM_read_data;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized traffic against a behavioural arbiter/SRAM model with a read-return scoreboard.
module tb_sram_arbiter;
  localparam int RL = 3;
  localparam int MB = 4;
  logic Clock = 0, Resetn = 0, SRAM_ready = 1;
  logic [1:0] Req = 0, Req_we_n = 2'b11;
  logic [35:0] Req_address = 0;
  logic [31:0] Req_write_data = 0;
  logic [1:0] Grant, Read_valid;
  logic [15:0] Read_data, SRAM_write_data, SRAM_read_data;
  logic [17:0] SRAM_address;
  logic SRAM_we_n;

  sram_arbiter #(.READ_LATENCY(RL), .MAX_BURST(MB)) dut (
    .Clock(Clock), .Resetn(Resetn), .SRAM_ready(SRAM_ready), .Req(Req), .Req_we_n(Req_we_n),
    .Req_address(Req_address), .Req_write_data(Req_write_data), .Grant(Grant), .Read_valid(Read_valid),
    .Read_data(Read_data), .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n(SRAM_we_n), .SRAM_read_data(SRAM_read_data)
  );

  always #5 Clock = ~Clock;

  typedef struct {int cyc; logic [15:0] data;} exp_t;
  exp_t q[2][$];
  logic [15:0] gmem[int], smem[int];
  int checks = 0, failures = 0, cyc = 0, own = -1, cnt = 0, last = 1;
  bit armed = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", n, cyc, a, e);
    end
  endtask

  // SRAM controller model: reads every cycle, returns data RL cycles later, writes when we_n=0.
  logic [17:0] cap_a = 0;
  logic [15:0] cap_d = 0;
  logic cap_we = 1;
  logic [15:0] rp[RL] = '{default: 16'h0};
  assign SRAM_read_data = rp[RL-1];
  always @(negedge Clock) begin
    cap_a  = $isunknown(SRAM_address) ? 18'h0 : SRAM_address;
    cap_d  = SRAM_write_data;
    cap_we = SRAM_we_n;
  end
  always @(posedge Clock) begin
    cyc++;
    for (int k = RL - 1; k > 0; k--) rp[k] = rp[k-1];
    rp[0] = smem.exists(int'(cap_a)) ? smem[int'(cap_a)] : cap_a[15:0] ^ 16'h5a5a;
    if (cap_we === 1'b0) smem[int'(cap_a)] = cap_d;
  end

  // Reference arbiter: checks this cycle's outputs, predicts read returns, then steps to the next cycle.
  always @(negedge Clock) begin
    int o;
    logic iss, w;
    logic [17:0] a;
    logic [15:0] d;
    o   = own < 0 ? 0 : own;
    a   = Req_address[o*18 +: 18];
    d   = Req_write_data[o*16 +: 16];
    w   = Req_we_n[o];
    iss = armed && SRAM_ready && own >= 0 && Req[o];
    if (armed) begin
      chk("grant", Grant, own < 0 ? 0 : 1 << own);
      chk("we_n", SRAM_we_n, iss ? w : 1);
      chk("address", SRAM_address, iss ? a : 0);
      chk("wdata", SRAM_write_data, iss ? d : 0);
      if (iss && w) q[o].push_back('{cyc + RL, gmem.exists(int'(a)) ? gmem[int'(a)] : a[15:0] ^ 16'h5a5a});
      if (iss && !w) gmem[int'(a)] = d;
    end
    if (!Resetn) begin
      own = -1; cnt = 0; last = 1; armed = 1;
      for (int i = 0; i < 2; i++) while (q[i].size() != 0 && q[i][$].cyc > cyc) void'(q[i].pop_back());
    end else if (armed) begin
      if (!SRAM_ready) begin own = -1; cnt = 0; end
      else if (own < 0) begin
        if (Req != 0) begin own = Req == 2'b11 ? 1 - last : (Req[0] ? 0 : 1); last = own; cnt = 0; end
      end else if (!Req[own]) begin
        own = Req[1-own] ? 1 - own : -1;
        if (own >= 0) last = own;
        cnt = 0;
      end else if (cnt == MB - 1) begin
        if (Req[1-own]) begin own = 1 - own; last = own; end
        cnt = 0;
      end else cnt++;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents read data.
  always @(negedge Clock) begin
    if (armed) for (int i = 0; i < 2; i++) begin
      exp_t e;
      if (Read_valid[i]) begin
        if (q[i].size() == 0) chk($sformatf("rv%0d_unexpected", i), 32'(Read_valid[i]), 0);
        else begin
          e = q[i].pop_front();
          chk($sformatf("rv%0d_cycle", i), cyc, e.cyc);
          chk($sformatf("rdata%0d", i), Read_data, e.data);
        end
      end else if (q[i].size() != 0 && q[i][0].cyc <= cyc) begin
        chk($sformatf("rv%0d_missing", i), 32'(Read_valid[i]), 1);
        void'(q[i].pop_front());
      end
    end
  end

  task automatic rnd_bus();
    for (int i = 0; i < 2; i++) begin
      Req_address[i*18 +: 18]    = 18'($urandom) & 18'h3000f;
      Req_write_data[i*16 +: 16] = 16'($urandom);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge Clock);
    #1 Resetn = 1;
    Req = 2'b11; Req_we_n = 2'b11;
    for (int k = 0; k < 20; k++) begin rnd_bus(); step(); end
    Req = 2'b01;
    for (int k = 0; k < 12; k++) begin rnd_bus(); Req_we_n = 2'($urandom); step(); end
    for (int k = 0; k < 3000; k++) begin
      Resetn     = k != 1500;
      SRAM_ready = $urandom_range(0, 15) != 0;
      for (int i = 0; i < 2; i++)
        if (Req[i]) begin if ($urandom_range(0, 7) == 0) Req[i] = 0; end
        else if ($urandom_range(0, 3) == 0) Req[i] = 1;
      Req_we_n = 2'($urandom);
      rnd_bus();
      step();
    end
    Resetn = 1; Req = 0; SRAM_ready = 1;
    repeat (RL + 3) step();
    @(negedge Clock);
    chk("drained0", q[0].size(), 0);
    chk("drained1", q[1].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Two-requester arbiter that shares the single SRAM_controller port (18-bit address, 16-bit data, active-low write enable, fixed read latency) between requesters such as the BIST engine and a second client. It sits between the requesters and SRAM_controller. It grants the port in round-robin order in bursts of bounded length, muxes address, write data and write enable onto the controller, and tags returning read data with a per-requester valid strobe.

Parameters:
READ_LATENCY, 3, clocks from a read access on the SRAM port to valid SRAM_read_data (range 1..8)
MAX_BURST, 16, maximum consecutive grant cycles before the port is re-arbitrated (range 1..256)

Ports:
Clock  in  1  system clock (50 MHz)
Resetn  in  1  synchronous active-low reset, sampled on rising Clock
SRAM_ready  in  1  controller ready; no grants while low
Req  in  2  per-requester request, held high while the requester wants the port
Req_we_n  in  2  per-requester write enable, active low
Req_address  in  2x18  per-requester address
Req_write_data  in  2x16  per-requester write data
Grant  out  2  one-hot or zero, registered; requester owns the port this cycle
Read_valid  out  2  SRAM_read_data belongs to requester i this cycle
Read_data  out  16  pass-through of SRAM_read_data
SRAM_address  out  18  to controller
SRAM_write_data  out  16  to controller
SRAM_we_n  out  1  to controller; 1 when no write is issued
SRAM_read_data  in  16  from controller

Behaviour:
- Reset (Resetn=0 at a rising edge): state IDLE, Grant=00, burst count 0, last_owner=1 (requester 0 wins the first tie), tag pipeline cleared (Read_valid=00). The SRAM outputs are combinational and show SRAM_we_n=1, address 0 and write data 0 while no access is issued.
- States: IDLE, OWN0, OWN1. Grant[i] = (state==OWNi).
- IDLE: if SRAM_ready=1 and any Req is high, go to OWNi. When both requests are high, the winner is the requester other than last_owner. last_owner is set to i on entry.
- Access issue: in state OWNi with Req[i]=1, an access is issued combinationally that cycle: SRAM_address=Req_address[i], SRAM_write_data=Req_write_data[i], SRAM_we_n=Req_we_n[i]. Any other cycle: SRAM_we_n=1, address and data 0.
- Latency: Req[i] rises at cycle t from IDLE, so Grant[i]=1 and the first access is issued at t+1. A read issued at cycle c gives Read_valid[i]=1 at c+READ_LATENCY.
- Burst count increments on each issued access. The count resets to 0 on any state change.
- Leave OWNi at the next edge when any of the following holds:
  - Req[i]=0: go to OWNj if Req[j] is high, else IDLE.
  - The count reaches MAX_BURST-1 on an issued access and Req[j]=1: go to OWNj.
  - The count reaches MAX_BURST-1 and Req[j]=0: stay in OWNi and reset the count (no starvation, no idle gap).
- Simultaneous Req[i] drop and burst expiry: treated as a drop.
- SRAM_ready=0: the next state is IDLE, and no access is issued in the current cycle even if Grant is high. Tags already in flight keep draining.
- Tag pipeline: READ_LATENCY stages of {valid, owner}. Valid = issued access with we_n=1; writes produce no Read_valid. Read_valid is never asserted for both requesters in the same cycle.
- Requesters must sample Grant before changing their address. Address/data changes while Req=1 and Grant=0 are ignored.

Decomposition:
- Package sram_arb_pkg:
  - state enum (S_IDLE, S_OWN0, S_OWN1)
  - SRAM_ADDR_W=18, SRAM_DATA_W=16
  - read tag struct {valid, owner}
- Sub-module sram_read_tag_pipe: a parameterised shift register of tags with synchronous reset.
- Arbiter FSM, burst counter and output mux live in the top module.

Test Plan:
- Single requester reads: Req=01, Req_we_n=1, addresses 0..3, READ_LATENCY=3 -> Grant=01 one cycle after Req rises; Read_valid[0] pulses 4 cycles, first at access cycle+3; Read_data equals the SRAM contents; Read_valid[1] stays 0.
- Tie after reset: both Req rise in the same cycle -> Grant=01 first. With MAX_BURST=4 the grants alternate 4 accesses to requester 0, then 4 to requester 1, repeating.
- Early release: requester 0 drops Req after 2 accesses while Req[1]=1 -> Grant=10 on the next edge; the count restarts and requester 1 gets 4 accesses.
- Sole requester at burst expiry: Req=01 held for 10 accesses, MAX_BURST=4 -> Grant stays 01 continuously; an access is issued every cycle with no gap.
- SRAM_ready drop: SRAM_ready=0 mid-burst with 2 reads in flight -> SRAM_we_n=1 and no new access that cycle; Grant=00 next cycle; both in-flight Read_valid pulses still arrive.
- Reset mid-operation: Resetn=0 for one edge during mixed read/write traffic -> Grant=00, Read_valid=00 at the next cycle, SRAM_we_n=1. After release, a tie goes to requester 0.
